pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Produces the per-stage enables and bubble/flush strobes consumed by the PC, IF/ID, ID/EX and EX/MEM registers. These include the ID/EX `id_shouldStall`, `exceptClear` and `cpu_en` inputs.
Detects load-use hazards, holds the pipe during multi-cycle memory waits, sequences exception flush and redirect, and supports debug single-step.

Parameters:
- EXC_FLUSH_CYCLES, 2, cycles `exceptClear` is held after an exception is accepted (1..7).
- MEM_TIMEOUT, 255, max consecutive `mem_busy` cycles before `mem_timeout` is flagged (8-bit counter).
- PERF_W, 16, width of the performance counters (optional feature only).

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- step_mode  in  1  1 = debug single-step mode
- step_pulse  in  1  one-cycle pulse; advances one pipeline cycle in step mode
- id_rs  in  5  rs field of the ID instruction
- id_rt  in  5  rt field of the ID instruction
- id_usesRs  in  1  ID instruction reads rs
- id_usesRt  in  1  ID instruction reads rt
- id_swSignalAndLastRtEqualCurrentRt  in  1  sw store-data is forwardable; no stall on rt
- ex_memOutOrAluOutWriteBackToRegFile  in  1  EX instruction is a load
- ex_ifWriteRegsFile  in  1  EX instruction writes the register file
- ex_registerWriteAddress  in  5  EX destination register
- id_shouldJumpOrBranch  in  1  taken jump/branch resolved in ID
- ex_undefined  in  1  undefined instruction in EX (exception request)
- mem_busy  in  1  data memory not ready this cycle
- cpu_en  out  1  global register enable
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID load-NOP strobe
- id_shouldStall  out  1  bubble into ID/EX
- exceptClear  out  1  flush ID/EX and younger stages
- pc_sel_exc  out  1  PC mux selects the exception vector
- mem_timeout  out  1  sticky memory-wait timeout flag
- busy_state  out  3  current FSM state encoding (debug)

Behaviour:
- Reset (`rst` at a rising edge): state=RUN, all counters 0, `mem_timeout`=0.
  - During reset cycles the outputs are `cpu_en`=1, `pc_en`=0, `ifid_en`=0, `ifid_flush`=1, `id_shouldStall`=1, `exceptClear`=1, `pc_sel_exc`=0.
  - This forces NOPs downstream.
- Load-use hazard (combinational, `lu`) is asserted when all of the following hold:
  - `ex_memOutOrAluOutWriteBackToRegFile` and `ex_ifWriteRegsFile` are both 1;
  - `ex_registerWriteAddress` != 0;
  - and either (`id_usesRs` and `id_rs`==`ex_registerWriteAddress`) or (`id_usesRt` and `id_rt`==`ex_registerWriteAddress` and !`id_swSignalAndLastRtEqualCurrentRt`).
- FSM states: RUN=0, MEM_WAIT=1, EXC_FLUSH=2, EXC_REDIRECT=3, STEP_HOLD=4.
- Priority within one cycle: exception > mem_busy > load-use > branch.
- RUN:
  - `ex_undefined` -> EXC_FLUSH, with the flush counter loaded to EXC_FLUSH_CYCLES-1; `exceptClear`=1 this same cycle.
  - else `mem_busy` -> MEM_WAIT; `cpu_en`=0 this same cycle.
  - else `lu` -> `pc_en`=0, `ifid_en`=0, `id_shouldStall`=1 for exactly one cycle; stay in RUN. The next cycle re-evaluates, and `lu` is naturally 0 after the bubble.
  - else `id_shouldJumpOrBranch` -> `ifid_flush`=1 for one cycle; `pc_en`=1.
  - else all enables are 1 and strobes are 0.
  - With `step_mode`=1 and no `step_pulse` -> STEP_HOLD.
- MEM_WAIT:
  - `cpu_en`=0 (all stages hold) while `mem_busy`=1; the wait counter increments and saturates at 255.
  - When the counter reaches MEM_TIMEOUT, `mem_timeout` is set and stays set until reset.
  - When `mem_busy`=0 -> RUN; the counter clears and `cpu_en`=1 in the exit cycle.
  - `ex_undefined` is ignored while `cpu_en`=0.
- EXC_FLUSH:
  - `exceptClear`=1, `ifid_flush`=1, `pc_en`=0.
  - The counter decrements; at 0 -> EXC_REDIRECT.
  - `mem_busy` during the flush freezes the counter (`cpu_en`=0).
- EXC_REDIRECT: one cycle with `pc_sel_exc`=1, `pc_en`=1, `ifid_flush`=1 -> RUN.
- STEP_HOLD:
  - `cpu_en`=0.
  - `step_pulse` -> `cpu_en`=1 for exactly one cycle with RUN-equivalent decisions; stay in STEP_HOLD if `step_mode`=1, else RUN.
  - `step_mode` deasserted without a pulse -> RUN next cycle.
- Reset mid-operation: from any state, reset returns to RUN with counters cleared. A pending exception is dropped.
- `busy_state` reflects the registered state.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- When defined, adds outputs `perf_lu_stalls`, `perf_mem_wait`, `perf_flushes`, each PERF_W bits wide.
  - They count, respectively, load-use bubble cycles, MEM_WAIT cycles, and exceptions accepted.
  - Each counter saturates at all-ones and is cleared by `rst`.
- When not defined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package `pipe_ctrl_pkg`:
  - state enum (RUN, MEM_WAIT, EXC_FLUSH, EXC_REDIRECT, STEP_HOLD) with 3-bit encoding;
  - exception vector constant 32'h0000_0008;
  - register width constant 5.
- One sub-module, `load_use_detect`: the purely combinational `lu` comparator, reused by the forwarding unit.

Test Plan:
- Load-use stall: EX lw $2, ID `add $3,$2,$4` (`id_usesRs`=1, `id_rs`=2) -> exactly one cycle of `id_shouldStall`=1, `pc_en`=0, `ifid_en`=0; the next cycle has all enables 1.
- sw forwarding: EX lw $5, ID sw with rt=5 and `id_swSignalAndLastRtEqualCurrentRt`=1 -> no stall. Same case with rs=5 -> one-cycle stall.
- Memory wait: `mem_busy` high for 4 cycles -> `cpu_en`=0 for 4 cycles and `busy_state`=1. Holding it 260 cycles -> `mem_timeout`=1 from cycle 255 onward, until `rst`.
- Exception with simultaneous load-use and branch: `ex_undefined`=1 -> `exceptClear`=1 for 2 cycles, then one cycle of `pc_sel_exc`=1, then RUN. No `id_shouldStall` is generated.
- Single-step: `step_mode`=1 with pulses at cycles 10 and 20 -> `cpu_en`=1 only at cycles 10 and 20. `step_mode`=0 at cycle 25 -> `cpu_en`=1 continuously from cycle 26.
- Reset in EXC_FLUSH: assert `rst` one cycle after the exception -> `busy_state`=0 next cycle and `pc_sel_exc` is never asserted.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional performance counters are enabled with the PIPE_HAZARD_PERF_EN macro
// (see pipe_hazard_ctrl.sv).
package pipe_ctrl_pkg;

    // Architectural register index width.
    localparam int REG_W = 5;

    // PC value loaded when an exception redirect is taken.
    localparam logic [31:0] EXC_VECTOR = 32'h0000_0008;

    // Sequencer states; the encoding is visible on busy_state.
    typedef enum logic [2:0] {
        RUN          = 3'd0,
        MEM_WAIT     = 3'd1,
        EXC_FLUSH    = 3'd2,
        EXC_REDIRECT = 3'd3,
        STEP_HOLD    = 3'd4
    } pipe_state_e;

    // Saturating 8-bit increment used by the memory-wait counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard comparator. Flags when the instruction in ID
// reads a register that a load in EX has not produced yet. The store-data
// path (rt of a sw) is exempt when the forwarding network can supply it.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic             ex_is_load,
    input  logic             ex_writes_rf,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_rt_fwd_ok,
    output logic             lu
);

    logic ex_producer;
    logic rs_hit;
    logic rt_hit;

    // A load writing a real register ($0 is never a hazard) matched by either source.
    always_comb begin
        ex_producer = ex_is_load && ex_writes_rf && (ex_rd != '0);
        rs_hit      = id_uses_rs && (id_rs == ex_rd);
        rt_hit      = id_uses_rt && (id_rt == ex_rd) && !id_rt_fwd_ok;
        lu          = ex_producer && (rs_hit || rt_hit);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Produces the per-stage enables and bubble/flush strobes, sequences
// exception flush + redirect, holds the pipe during memory waits and
// supports debug single-step. Control outputs are decoded combinationally
// from the registered state and the current hazard inputs so that a
// stall or flush takes effect in the cycle it is detected.
// Optional feature: define PIPE_HAZARD_PERF_EN to add saturating
// performance counters perf_lu_stalls, perf_mem_wait and perf_flushes.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int EXC_FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT      = 255
`ifdef PIPE_HAZARD_PERF_EN
    ,
    parameter int PERF_W           = 16
`endif
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             step_mode,
    input  logic             step_pulse,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_usesRs,
    input  logic             id_usesRt,
    input  logic             id_swSignalAndLastRtEqualCurrentRt,
    input  logic             ex_memOutOrAluOutWriteBackToRegFile,
    input  logic             ex_ifWriteRegsFile,
    input  logic [REG_W-1:0] ex_registerWriteAddress,
    input  logic             id_shouldJumpOrBranch,
    input  logic             ex_undefined,
    input  logic             mem_busy,
    output logic             cpu_en,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             id_shouldStall,
    output logic             exceptClear,
    output logic             pc_sel_exc,
    output logic             mem_timeout,
    output logic [2:0]       busy_state
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_lu_stalls,
    output logic [PERF_W-1:0] perf_mem_wait,
    output logic [PERF_W-1:0] perf_flushes
`endif
);

    localparam logic [2:0] FLUSH_LOAD  = 3'(EXC_FLUSH_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    pipe_state_e state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        mem_timeout_q, mem_timeout_d;
    logic        lu;
    logic        run_decide;

    load_use_detect u_lu (
        .ex_is_load   (ex_memOutOrAluOutWriteBackToRegFile),
        .ex_writes_rf (ex_ifWriteRegsFile),
        .ex_rd        (ex_registerWriteAddress),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_usesRs),
        .id_uses_rt   (id_usesRt),
        .id_rt_fwd_ok (id_swSignalAndLastRtEqualCurrentRt),
        .lu           (lu)
    );

    // Next-state, counter updates and per-stage control decode.
    always_comb begin
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        run_decide     = 1'b0;
        cpu_en         = 1'b1;
        pc_en          = 1'b1;
        ifid_en        = 1'b1;
        ifid_flush     = 1'b0;
        id_shouldStall = 1'b0;
        exceptClear    = 1'b0;
        pc_sel_exc     = 1'b0;

        case (state_q)
            RUN: begin
                // Entering single-step freezes the pipe immediately.
                if (step_mode && !step_pulse) begin
                    cpu_en  = 1'b0;
                    state_d = STEP_HOLD;
                end else begin
                    run_decide = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_busy) begin
                    cpu_en     = 1'b0;
                    wait_cnt_d = sat_inc8(wait_cnt_q);
                end else begin
                    // Exit cycle: pipe advances and makes normal RUN decisions.
                    wait_cnt_d = 8'd0;
                    state_d    = RUN;
                    run_decide = 1'b1;
                end
            end
            EXC_FLUSH: begin
                exceptClear = 1'b1;
                ifid_flush  = 1'b1;
                pc_en       = 1'b0;
                if (mem_busy) begin
                    // Memory stall freezes the flush sequence in place.
                    cpu_en = 1'b0;
                end else if (flush_cnt_q <= 3'd1) begin
                    flush_cnt_d = 3'd0;
                    state_d     = EXC_REDIRECT;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end
            EXC_REDIRECT: begin
                pc_sel_exc = 1'b1;
                pc_en      = 1'b1;
                ifid_flush = 1'b1;
                state_d    = RUN;
            end
            STEP_HOLD: begin
                if (step_pulse) begin
                    run_decide = 1'b1;
                end else begin
                    cpu_en = 1'b0;
                    if (!step_mode) begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // RUN-equivalent decision: exception > mem_busy > load-use > branch.
        if (run_decide) begin
            if (ex_undefined) begin
                exceptClear = 1'b1;
                ifid_flush  = 1'b1;
                pc_en       = 1'b0;
                if (EXC_FLUSH_CYCLES <= 1) begin
                    state_d = EXC_REDIRECT;
                end else begin
                    state_d     = EXC_FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end
            end else if (mem_busy) begin
                cpu_en     = 1'b0;
                state_d    = MEM_WAIT;
                wait_cnt_d = 8'd1;
            end else if (lu) begin
                pc_en          = 1'b0;
                ifid_en        = 1'b0;
                id_shouldStall = 1'b1;
            end else if (id_shouldJumpOrBranch) begin
                ifid_flush = 1'b1;
            end
        end

        // A step pulse taken with step_mode already dropped releases the hold.
        if (state_d == STEP_HOLD && !step_mode) begin
            state_d = RUN;
        end

        mem_timeout_d = mem_timeout_q || (wait_cnt_d >= TIMEOUT_CNT);

        // Reset forces NOPs into every downstream register.
        if (rst) begin
            cpu_en         = 1'b1;
            pc_en          = 1'b0;
            ifid_en        = 1'b0;
            ifid_flush     = 1'b1;
            id_shouldStall = 1'b1;
            exceptClear    = 1'b1;
            pc_sel_exc     = 1'b0;
        end
    end

    // State, counters and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            flush_cnt_q   <= 3'd0;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign busy_state  = state_q;

`ifdef PIPE_HAZARD_PERF_EN
    logic [PERF_W-1:0] perf_lu_q, perf_lu_d;
    logic [PERF_W-1:0] perf_mw_q, perf_mw_d;
    logic [PERF_W-1:0] perf_fl_q, perf_fl_d;
    logic              exc_accept;

    // Saturating event counters; an exception is accepted when exceptClear
    // rises outside the flush state.
    always_comb begin
        exc_accept = exceptClear && !rst && (state_q != EXC_FLUSH);
        perf_lu_d  = perf_lu_q;
        perf_mw_d  = perf_mw_q;
        perf_fl_d  = perf_fl_q;
        if (id_shouldStall && !rst && perf_lu_q != '1) begin
            perf_lu_d = perf_lu_q + 1'b1;
        end
        if (state_q == MEM_WAIT && perf_mw_q != '1) begin
            perf_mw_d = perf_mw_q + 1'b1;
        end
        if (exc_accept && perf_fl_q != '1) begin
            perf_fl_d = perf_fl_q + 1'b1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu_q <= '0;
            perf_mw_q <= '0;
            perf_fl_q <= '0;
        end else begin
            perf_lu_q <= perf_lu_d;
            perf_mw_q <= perf_mw_d;
            perf_fl_q <= perf_fl_d;
        end
    end

    assign perf_lu_stalls = perf_lu_q;
    assign perf_mem_wait  = perf_mw_q;
    assign perf_flushes   = perf_fl_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a
// randomized run, all compared every cycle against a behavioural model
// that tracks the pipeline situation (waiting, flush cycles left,
// redirect pending, single-step hold) rather than the RTL state machine.
module tb_pipe_hazard_ctrl;

    localparam int EXC_N = 2;
    localparam int TMO   = 255;

    logic       clk = 1'b0;
    logic       rst;
    logic       step_mode, step_pulse;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_usesRs, id_usesRt, id_swfwd;
    logic       ex_load, ex_wr, id_br, ex_undefined, mem_busy;
    logic       cpu_en, pc_en, ifid_en, ifid_flush, id_shouldStall;
    logic       exceptClear, pc_sel_exc, mem_timeout;
    logic [2:0] busy_state;
`ifdef PIPE_HAZARD_PERF_EN
    logic [15:0] perf_lu_stalls, perf_mem_wait, perf_flushes;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.EXC_FLUSH_CYCLES(EXC_N), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .step_mode(step_mode),
        .step_pulse(step_pulse),
        .id_rs(id_rs),
        .id_rt(id_rt),
        .id_usesRs(id_usesRs),
        .id_usesRt(id_usesRt),
        .id_swSignalAndLastRtEqualCurrentRt(id_swfwd),
        .ex_memOutOrAluOutWriteBackToRegFile(ex_load),
        .ex_ifWriteRegsFile(ex_wr),
        .ex_registerWriteAddress(ex_rd),
        .id_shouldJumpOrBranch(id_br),
        .ex_undefined(ex_undefined),
        .mem_busy(mem_busy),
        .cpu_en(cpu_en),
        .pc_en(pc_en),
        .ifid_en(ifid_en),
        .ifid_flush(ifid_flush),
        .id_shouldStall(id_shouldStall),
        .exceptClear(exceptClear),
        .pc_sel_exc(pc_sel_exc),
        .mem_timeout(mem_timeout),
        .busy_state(busy_state)
`ifdef PIPE_HAZARD_PERF_EN
        ,
        .perf_lu_stalls(perf_lu_stalls),
        .perf_mem_wait(perf_mem_wait),
        .perf_flushes(perf_flushes)
`endif
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model of the pipeline situation.
    bit m_wait, m_redirect, m_hold, m_timeout;
    int m_busy_run, m_flush_left;
    bit n_wait, n_redirect, n_hold, n_timeout;
    int n_busy_run, n_flush_left;

    // {cpu_en, pc_en, ifid_en, ifid_flush, stall, exceptClear, pc_sel_exc, mem_timeout, state[2:0]}
    logic [10:0] exp_v;
    logic [10:0] obs_v;
    assign obs_v = {cpu_en, pc_en, ifid_en, ifid_flush, id_shouldStall, exceptClear,
                    pc_sel_exc, mem_timeout, busy_state};

    function automatic bit lu_ref();
        bit src_rs, src_rt;
        if (!(ex_load && ex_wr) || ex_rd == 5'd0) return 1'b0;
        src_rs = id_usesRs && (id_rs == ex_rd);
        src_rt = id_usesRt && (id_rt == ex_rd) && !id_swfwd;
        return src_rs || src_rt;
    endfunction

    // Expected outputs for the current cycle plus the model's next situation.
    function automatic void model_eval();
        bit cpu, pc, ifid, fl, st, ex, sel, dec;
        int stn;
        n_wait = m_wait; n_redirect = m_redirect; n_hold = m_hold;
        n_timeout = m_timeout; n_busy_run = m_busy_run; n_flush_left = m_flush_left;
        cpu = 1; pc = 1; ifid = 1; fl = 0; st = 0; ex = 0; sel = 0; dec = 0;
        stn = m_wait ? 1 : (m_flush_left > 0) ? 2 : m_redirect ? 3 : m_hold ? 4 : 0;
        if (m_wait) begin
            if (mem_busy) begin
                cpu = 0;
                n_busy_run = m_busy_run + 1;
            end else begin
                n_wait = 0; n_busy_run = 0; dec = 1;
            end
        end else if (m_flush_left > 0) begin
            ex = 1; fl = 1; pc = 0;
            if (mem_busy) cpu = 0;
            else begin
                n_flush_left = m_flush_left - 1;
                if (n_flush_left == 0) n_redirect = 1;
            end
        end else if (m_redirect) begin
            sel = 1; fl = 1; n_redirect = 0;
        end else if (m_hold) begin
            if (step_pulse) dec = 1;
            else begin
                cpu = 0;
                if (!step_mode) n_hold = 0;
            end
        end else begin
            if (step_mode && !step_pulse) begin
                cpu = 0; n_hold = 1;
            end else dec = 1;
        end
        if (dec) begin
            if (ex_undefined) begin
                ex = 1; fl = 1; pc = 0; n_hold = 0;
                if (EXC_N == 1) n_redirect = 1;
                else n_flush_left = EXC_N - 1;
            end else if (mem_busy) begin
                cpu = 0; n_wait = 1; n_busy_run = 1; n_hold = 0;
            end else if (lu_ref()) begin
                pc = 0; ifid = 0; st = 1;
            end else if (id_br) begin
                fl = 1;
            end
            if (n_hold && !step_mode) n_hold = 0;
        end
        if (n_busy_run >= TMO) n_timeout = 1;
        if (rst) begin
            cpu = 1; pc = 0; ifid = 0; fl = 1; st = 1; ex = 1; sel = 0;
            n_wait = 0; n_redirect = 0; n_hold = 0; n_timeout = 0;
            n_busy_run = 0; n_flush_left = 0;
        end
        exp_v = {cpu, pc, ifid, fl, st, ex, sel, m_timeout, 3'(stn)};
    endfunction

    function automatic void model_commit();
        m_wait = n_wait; m_redirect = n_redirect; m_hold = n_hold;
        m_timeout = n_timeout; m_busy_run = n_busy_run; m_flush_left = n_flush_left;
    endfunction

    task automatic idle_inputs();
        step_mode = 0; step_pulse = 0;
        id_rs = 0; id_rt = 0; ex_rd = 0;
        id_usesRs = 0; id_usesRt = 0; id_swfwd = 0;
        ex_load = 0; ex_wr = 0; id_br = 0; ex_undefined = 0; mem_busy = 0;
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_eval();
        model_commit();
        cyc++;
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1; idle_inputs();
        advance();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        advance();
        settle();
        checks++;
        if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL reset_model cyc=%0d got=%b exp=%b", cyc, obs_v, exp_v);
        end
        checks++;
        if ({cpu_en, pc_en, ifid_en, ifid_flush, id_shouldStall, exceptClear, pc_sel_exc, busy_state} !== 10'b1001110_000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b",
                     {cpu_en, pc_en, ifid_en, ifid_flush, id_shouldStall, exceptClear, pc_sel_exc, busy_state}, 10'b1001110_000);
        end
        advance();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if (obs_v !== exp_v || obs_v !== 11'b11100000_000) begin
                failures++;
                $display("FAIL post_reset_idle cyc=%0d got=%b exp=%b", cyc, obs_v, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_load_use();
        int stalls = 0;
        idle_inputs();
        // EX: lw $2 ; ID: add $3,$2,$4
        ex_load = 1; ex_wr = 1; ex_rd = 5'd2;
        id_usesRs = 1; id_rs = 5'd2; id_usesRt = 1; id_rt = 5'd4;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL load_use cyc=%0d got=%b exp=%b", cyc, obs_v, exp_v);
            end
            if (id_shouldStall === 1'b1) stalls++;
            advance();
            // After the bubble the load has moved on; EX now holds a NOP.
            ex_load = 0; ex_wr = 0; ex_rd = 0;
        end
        checks++;
        if (stalls !== 1) begin
            failures++;
            $display("FAIL load_use_stall_count got=%0d exp=1", stalls);
        end
    endtask

    task automatic test_sw_forward();
        idle_inputs();
        // EX: lw $5 ; ID: sw with rt=5, store data forwardable
        ex_load = 1; ex_wr = 1; ex_rd = 5'd5;
        id_usesRs = 1; id_rs = 5'd1; id_usesRt = 1; id_rt = 5'd5; id_swfwd = 1;
        settle();
        checks++;
        if (obs_v !== exp_v || id_shouldStall !== 1'b0) begin
            failures++;
            $display("FAIL sw_fwd_nostall cyc=%0d got=%b exp=%b", cyc, obs_v, exp_v);
        end
        advance();
        // Same store but base register also $5 -> stall.
        id_rs = 5'd5;
        settle();
        checks++;
        if (obs_v !== exp_v || id_shouldStall !== 1'b1) begin
            failures++;
            $display("FAIL sw_rs_stall cyc=%0d got=%b exp=%b", cyc, obs_v, exp_v);
        end
        advance();
        // Load to $0 never stalls.
        idle_inputs();
        ex_load = 1; ex_wr = 1; ex_rd = 5'd0; id_usesRs = 1; id_rs = 5'd0;
        settle();
        checks++;
        if (obs_v !== exp_v || id_shouldStall !== 1'b0) begin
            failures++;
            $display("FAIL lu_r0 cyc=%0d got=%b exp=%b", cyc, obs_v, exp_v);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_mem_wait();
        int held = 0, waits = 0;
        idle_inputs();
        for (int i = 0; i < 7; i++) begin
            mem_busy = (i >= 1 && i <= 4);
            settle();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL mem_wait cyc=%0d got=%b exp=%b", cyc, obs_v, exp_v);
            end
            if (cpu_en === 1'b0) held++;
            if (busy_state === 3'd1) waits++;
            advance();
        end
        mem_busy = 0;
        checks++;
        if (held !== 4 || waits !== 4) begin
            failures++;
            $display("FAIL mem_wait_counts held=%0d waits=%0d exp=4/4", held, waits);
        end
    endtask

    task automatic test_mem_timeout();
        idle_inputs();
        mem_busy = 1;
        for (int i = 1; i <= 260; i++) begin
            settle();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL mem_timeout cyc=%0d got=%b exp=%b", cyc, obs_v, exp_v);
            end
            // i-1 busy edges have completed when cycle i is sampled.
            if (i == 255 || i == 256) begin
                checks++;
                if (mem_timeout !== (i == 256)) begin
                    failures++;
                    $display("FAIL timeout_edge busy_cycles=%0d got=%b exp=%b", i - 1, mem_timeout, i == 256);
                end
            end
            advance();
        end
        mem_busy = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if (obs_v !== exp_v || mem_timeout !== 1'b1) begin
                failures++;
                $display("FAIL timeout_sticky cyc=%0d got=%b exp=%b", cyc, obs_v, exp_v);
            end
            advance();
        end
        pulse_reset();
        settle();
        checks++;
        if (mem_timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_cleared got=%b exp=0", mem_timeout);
        end
        advance();
    endtask

    task automatic test_exception();
        int clr = 0, sel = 0, st = 0;
        idle_inputs();
        ex_undefined = 1; id_br = 1;
        ex_load = 1; ex_wr = 1; ex_rd = 5'd7; id_usesRs = 1; id_rs = 5'd7;
        for (int i = 0; i < 6; i++) begin
            settle();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL exception cyc=%0d got=%b exp=%b", cyc, obs_v, exp_v);
            end
            clr += int'(exceptClear);
            sel += int'(pc_sel_exc);
            st  += int'(id_shouldStall);
            advance();
            idle_inputs();
        end
        checks++;
        if (clr !== EXC_N || sel !== 1 || st !== 0 || busy_state !== 3'd0) begin
            failures++;
            $display("FAIL exception_seq clr=%0d sel=%0d stall=%0d state=%0d exp=%0d/1/0/0",
                     clr, sel, st, busy_state, EXC_N);
        end
    endtask

    task automatic test_step();
        int bad = 0;
        idle_inputs();
        for (int c = 0; c <= 30; c++) begin
            step_mode  = (c < 25);
            step_pulse = (c == 10 || c == 20);
            settle();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL step cyc=%0d c=%0d got=%b exp=%b", cyc, c, obs_v, exp_v);
            end
            if (cpu_en !== (c == 10 || c == 20 || c >= 26)) bad++;
            advance();
        end
        idle_inputs();
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL step_cpu_en_pattern got=%0d wrong cycles exp=0", bad);
        end
    endtask

    task automatic test_reset_in_flush();
        int sel = 0;
        idle_inputs();
        ex_undefined = 1;
        settle();
        checks++;
        if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL rst_flush_accept cyc=%0d got=%b exp=%b", cyc, obs_v, exp_v);
        end
        advance();
        idle_inputs();
        rst = 1;
        advance();
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            settle();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL rst_flush cyc=%0d got=%b exp=%b", cyc, obs_v, exp_v);
            end
            if (i == 0) begin
                checks++;
                if (busy_state !== 3'd0) begin
                    failures++;
                    $display("FAIL rst_flush_state got=%0d exp=0", busy_state);
                end
            end
            sel += int'(pc_sel_exc);
            advance();
        end
        checks++;
        if (sel !== 0) begin
            failures++;
            $display("FAIL rst_flush_no_redirect got=%0d exp=0", sel);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 39) == 0) step_mode = ~step_mode;
            step_pulse   = ($urandom_range(0, 3) == 0);
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            id_usesRs    = 1'($urandom);
            id_usesRt    = 1'($urandom);
            id_swfwd     = 1'($urandom);
            ex_load      = 1'($urandom);
            ex_wr        = ($urandom_range(0, 3) != 0);
            id_br        = ($urandom_range(0, 4) == 0);
            ex_undefined = ($urandom_range(0, 19) == 0);
            mem_busy     = ($urandom_range(0, 6) == 0);
            settle();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs_v, exp_v);
            end
            advance();
        end
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        m_wait = 0; m_redirect = 0; m_hold = 0; m_timeout = 0;
        m_busy_run = 0; m_flush_left = 0;
        idle_inputs();
        rst = 1;
        test_reset();
        test_load_use();
        test_sw_forward();
        test_mem_wait();
        test_mem_timeout();
        test_exception();
        test_step();
        test_reset_in_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
